// File: rtl/rr_mux_n_1.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_n_1
// Purpose  : Registered N:1 stream multiplexer with valid/ready handshakes on
//            every input and on the output. An internal arbiter picks the
//            source channel. It uses round-robin (MODE=0) or fixed priority
//            with the lowest index winning (MODE=1). The output register gives
//            one cycle of latency. It accepts a new word in the same cycle it
//            drains the previous one, so a continuously ready consumer sees
//            full throughput.
//
// Ports    : clk        - clock; all state updates on the rising edge
//            rst_n      - asynchronous active-low reset
//            in_valid   - [N]   channel i presents data
//            in_data    - [N*W] channel i occupies bits [i*W +: W]
//            in_ready   - [N]   channel i's word is accepted this cycle
//                                (at most one bit high)
//            out_valid  - output register holds a valid word
//            out_data   - [W]   registered selected word
//            out_sel    - [SW]  index of the channel that supplied out_data
//            out_ready  - consumer accepts the output this cycle
//
// Revision : 1.0 - initial release
// ============================================================================
module rr_mux_n_1 #(
    parameter  int W    = 4,
    parameter  int N    = 4,
    parameter  int MODE = 0,
    localparam int SW   = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     in_valid,
    input  logic [N*W-1:0]   in_data,
    output logic [N-1:0]     in_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [SW-1:0]    out_sel,
    input  logic             out_ready
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic          r_out_valid;
    logic [W-1:0]  r_out_data;
    logic [SW-1:0] r_out_sel;
    logic [SW-1:0] r_ptr;        // next round-robin start; unused in MODE=1

    // ------------------------------------------------------------------------
    // Combinational arbitration
    // ------------------------------------------------------------------------
    logic          w_load_en;    // output register empty or draining now
    logic          w_any;        // at least one channel is valid
    logic          w_accept;     // a word is taken from the granted channel
    logic [SW-1:0] w_start;      // first index of the circular scan
    logic [SW-1:0] w_grant;      // granted channel (meaningful when w_any)
    logic [SW-1:0] w_ptr_next;
    logic [W-1:0]  w_grant_data;

    assign w_load_en = !r_out_valid || out_ready;

    // Fixed priority is the same scan, always starting at channel 0.
    assign w_start = (MODE == 1) ? '0 : r_ptr;

    // The circular scan start, start+1, ..., N-1, 0, ..., start-1 is done as
    // two linear passes. The upper pass covers indices at or above the start.
    // The lower pass covers indices below it. A hit in the upper pass beats
    // any hit in the lower pass. No modulo arithmetic is needed, so
    // non-power-of-two N cannot produce an out-of-range index.
    always_comb begin
        logic          v_hi_found;
        logic          v_lo_found;
        logic [SW-1:0] v_hi_idx;
        logic [SW-1:0] v_lo_idx;
        v_hi_found = 1'b0;
        v_lo_found = 1'b0;
        v_hi_idx   = '0;
        v_lo_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (in_valid[i]) begin
                if (i >= int'(w_start)) begin
                    if (!v_hi_found) begin
                        v_hi_found = 1'b1;
                        v_hi_idx   = SW'(i);
                    end
                end else if (!v_lo_found) begin
                    v_lo_found = 1'b1;
                    v_lo_idx   = SW'(i);
                end
            end
        end
        w_any   = v_hi_found || v_lo_found;
        w_grant = v_hi_found ? v_hi_idx : v_lo_idx;
    end

    // Data select for the granted channel.
    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant == SW'(i)) begin
                w_grant_data = in_data[i*W +: W];
            end
        end
    end

    // Pointer advance with an explicit wrap at N-1.
    assign w_ptr_next = (w_grant == SW'(N - 1)) ? '0 : (w_grant + SW'(1));

    // in_ready is gated by rst_n so that no channel sees a handshake while
    // reset is asserted. Without the gate, an empty output register would
    // otherwise signal acceptance during reset.
    assign w_accept = rst_n && w_load_en && w_any;

    for (genvar gi = 0; gi < N; gi++) begin : g_ready
        assign in_ready[gi] = w_accept && (w_grant == SW'(gi));
    end

    // ------------------------------------------------------------------------
    // Output register and round-robin pointer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
        end else if (w_load_en) begin
            if (w_any) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_grant_data;
                r_out_sel   <= w_grant;
                r_ptr       <= w_ptr_next;
            end else begin
                // Drained with nothing to replace it: data, sel and ptr hold.
                r_out_valid <= 1'b0;
            end
        end
        // Stall (!w_load_en): everything holds.
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_n_1.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_mux_n_1
// Purpose  : Directed self-checking bench for rr_mux_n_1. It uses three
//            instances: N=4 round-robin, N=3 round-robin and N=4 fixed
//            priority. All three share the clock and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_mux_n_1;

    logic clk;
    logic rst_n;

    // N=4, MODE=0
    logic [3:0]  a_valid;
    logic [15:0] a_data;
    logic [3:0]  a_ready;
    logic        a_ov;
    logic [3:0]  a_od;
    logic [1:0]  a_os;
    logic        a_or;

    // N=3, MODE=0
    logic [2:0]  b_valid;
    logic [11:0] b_data;
    logic [2:0]  b_ready;
    logic        b_ov;
    logic [3:0]  b_od;
    logic [1:0]  b_os;
    logic        b_or;

    // N=4, MODE=1
    logic [3:0]  c_valid;
    logic [15:0] c_data;
    logic [3:0]  c_ready;
    logic        c_ov;
    logic [3:0]  c_od;
    logic [1:0]  c_os;
    logic        c_or;

    int n_tests = 0;
    int n_fail  = 0;

    rr_mux_n_1 #(.W(4), .N(4), .MODE(0)) u_rr4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_valid), .in_data(a_data), .in_ready(a_ready),
        .out_valid(a_ov), .out_data(a_od), .out_sel(a_os), .out_ready(a_or)
    );

    rr_mux_n_1 #(.W(4), .N(3), .MODE(0)) u_rr3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_valid), .in_data(b_data), .in_ready(b_ready),
        .out_valid(b_ov), .out_data(b_od), .out_sel(b_os), .out_ready(b_or)
    );

    rr_mux_n_1 #(.W(4), .N(4), .MODE(1)) u_fp4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c_valid), .in_data(c_data), .in_ready(c_ready),
        .out_valid(c_ov), .out_data(c_od), .out_sel(c_os), .out_ready(c_or)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset with arbitrary inputs ----------------
        rst_n   = 1'b0;
        a_valid = 4'hF; a_data = 16'h9C3E; a_or = 1'b1;
        b_valid = 3'b000; b_data = 12'h321; b_or = 1'b1;
        c_valid = 4'b0000; c_data = 16'hDCBA; c_or = 1'b1;
        #1;
        chk("rst_ov",    32'(a_ov),    32'h0);
        chk("rst_od",    32'(a_od),    32'h0);
        chk("rst_os",    32'(a_os),    32'h0);
        chk("rst_ready", 32'(a_ready), 32'h0);
        tick(); tick();
        chk("rst_ov_clk",    32'(a_ov),    32'h0);
        chk("rst_ready_clk", 32'(a_ready), 32'h0);

        // Release with only channel 2 valid, data 0xA.
        rst_n   = 1'b1;
        a_valid = 4'b0100; a_data = 16'h0A00;
        #1;
        chk("rel_ready", 32'(a_ready), 32'h4);
        tick();
        chk("rel_ov", 32'(a_ov), 32'h1);
        chk("rel_od", 32'(a_od), 32'hA);
        chk("rel_os", 32'(a_os), 32'h2);

        // Pulse reset so the round-robin pointer starts at 0 again.
        a_valid = 4'h0;
        rst_n   = 1'b0;
        tick();
        rst_n   = 1'b1;
        chk("rst2_ov", 32'(a_ov), 32'h0);

        // ---------------- round-robin, all valid ----------------
        a_valid = 4'hF;
        a_data  = {4'h8, 4'h7, 4'h6, 4'h5};
        a_or    = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_ready", 32'(a_ready), 32'(1) << (k % 4));
            tick();
            chk("rr_ov", 32'(a_ov), 32'h1);
            chk("rr_os", 32'(a_os), 32'(k % 4));
            chk("rr_od", 32'(a_od), 32'((k % 4) + 5));
        end
        // The last grant was channel 1, so ptr is now 2.

        // ---------------- backpressure ----------------
        a_or = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ready", 32'(a_ready), 32'h0);
            tick();
            chk("bp_ov", 32'(a_ov), 32'h1);
            chk("bp_od", 32'(a_od), 32'h6);
            chk("bp_os", 32'(a_os), 32'h1);
        end
        a_or = 1'b1;
        #1;
        chk("bp_resume_ready", 32'(a_ready), 32'h4);
        tick();
        chk("bp_resume_os", 32'(a_os), 32'h2);
        chk("bp_resume_od", 32'(a_od), 32'h7);

        // Empty-drain on A: output falls and data/sel hold.
        a_valid = 4'h0;
        tick();
        chk("drain_ov", 32'(a_ov), 32'h0);
        chk("drain_os", 32'(a_os), 32'h2);
        chk("drain_od", 32'(a_od), 32'h7);

        // ---------------- sparse and wrap, N=3 ----------------
        b_valid = 3'b101;
        b_data  = {4'h3, 4'h2, 4'h1};
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("sp_ready", 32'(b_ready), (k % 2 == 0) ? 32'h1 : 32'h4);
            tick();
            chk("sp_os", 32'(b_os), (k % 2 == 0) ? 32'h0 : 32'h2);
            chk("sp_od", 32'(b_od), (k % 2 == 0) ? 32'h1 : 32'h3);
        end
        // The last grant was channel 0, so ptr is 1. Drop all valid for one cycle.
        b_valid = 3'b000;
        #1;
        chk("sp_gap_ready", 32'(b_ready), 32'h0);
        tick();
        chk("sp_gap_ov", 32'(b_ov), 32'h0);
        chk("sp_gap_os", 32'(b_os), 32'h0);
        b_valid = 3'b111;
        #1;
        chk("sp_res_ready", 32'(b_ready), 32'h2);
        tick();
        chk("sp_res_ov", 32'(b_ov), 32'h1);
        chk("sp_res_os", 32'(b_os), 32'h1);
        chk("sp_res_od", 32'(b_od), 32'h2);
        tick();
        chk("sp_wrap_os2", 32'(b_os), 32'h2);
        tick();
        chk("sp_wrap_os0", 32'(b_os), 32'h0);
        chk("sp_wrap_od0", 32'(b_od), 32'h1);
        b_valid = 3'b000;

        // ---------------- fixed priority, MODE=1 ----------------
        c_valid = 4'b1011;
        c_data  = {4'hD, 4'hC, 4'hB, 4'hA};
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("fp_ready", 32'(c_ready), 32'h1);
            tick();
            chk("fp_os", 32'(c_os), 32'h0);
            chk("fp_od", 32'(c_od), 32'hA);
        end
        c_valid = 4'b1010;
        #1;
        chk("fp_drop_ready", 32'(c_ready), 32'h2);
        tick();
        chk("fp_drop_os", 32'(c_os), 32'h1);
        chk("fp_drop_od", 32'(c_od), 32'hB);
        c_valid = 4'b0000;

        // ---------------- reset mid-stream ----------------
        a_valid = 4'hF;
        a_data  = {4'h8, 4'h7, 4'h6, 4'h5};
        tick();
        chk("mid_pre_ov", 32'(a_ov), 32'h1);
        #2;
        rst_n = 1'b0;   // asserted between clock edges
        #1;
        chk("mid_ov",    32'(a_ov),    32'h0);
        chk("mid_od",    32'(a_od),    32'h0);
        chk("mid_os",    32'(a_os),    32'h0);
        chk("mid_ready", 32'(a_ready), 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid_rel_ready", 32'(a_ready), 32'h1);
        tick();
        chk("mid_rel_os", 32'(a_os), 32'h0);
        chk("mid_rel_od", 32'(a_od), 32'h5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_mux_n_1.md
# rr_mux_n_1

Parametrised, registered N:1 multiplexer with valid/ready handshakes on every input and on the output. It generalises the 4:1 combinational select into an arbitrating stream mux: an internal round-robin (or fixed-priority) arbiter chooses the input, with no external `sel`. It sits between several producer streams and one shared consumer and provides one-cycle registered latency and full throughput.

## Interface
- `W`, default 4: data width per channel in bits; must be ≥ 1.
- `N`, default 4: number of input channels; must be ≥ 2, need not be a power of two.
- `MODE`, default 0: 0 selects round-robin arbitration, 1 selects fixed priority (lowest index wins).
- `SW`: localparam, `$clog2(N)`.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  N  bit i is high when channel i presents data.
- `in_data`  in  N*W  channel i occupies bits [i*W +: W].
- `in_ready`  out  N  bit i is high when channel i's data is accepted this cycle.
- `out_valid`  out  1  output register holds a valid word.
- `out_data`  out  W  registered selected word.
- `out_sel`  out  SW  index of the channel that supplied `out_data`.
- `out_ready`  in  1  consumer accepts the output this cycle.

## Operation
- `load_en = !out_valid || out_ready`: the output register is empty, or it is being drained this cycle.
- Arbitration is combinational:
  - `MODE=0`: the grant is the first `i` with `in_valid[i]`, scanning `ptr, ptr+1, …, N-1, 0, …, ptr-1`.
  - `MODE=1`: the same scan starts at 0.
- `in_ready[g] = load_en && in_valid[g]` for the granted index `g`. All other bits are 0.
  - At most one `in_ready` bit is high in any cycle.
  - `in_ready` depends combinationally on `in_valid` and `out_ready`. Producers must not derive `in_valid` from `in_ready`.
- On a clock edge with `load_en` and any `in_valid` set:
  - `out_data <= in_data[g]`, `out_sel <= g`, `out_valid <= 1`.
  - `ptr <= (g == N-1) ? 0 : g+1`. The wrap is explicit, so non-power-of-two N never produces an out-of-range index.
- On a clock edge with `load_en` and no `in_valid`: `out_valid <= 0`. `out_data`, `out_sel` and `ptr` hold.
- On a clock edge with `!load_en` (stall): all state holds and no input is accepted.
- `ptr` exists in both modes and is ignored when `MODE=1`.
- A transfer occurs on an input when `in_valid[i] && in_ready[i]`, and on the output when `out_valid && out_ready`.
- Reset (async assert, sampled release):
  - `out_valid=0`, `out_data=0`, `out_sel=0`, `ptr=0`.
  - `in_ready=0` while `rst_n=0`.
- Reset asserted mid-operation discards any held word. It is neither delivered nor replayed.

## Timing
- Latency is 1 cycle: a word accepted at edge k is on `out_data` with `out_valid=1` after edge k.
- Throughput is 1 word per cycle when `out_ready` is held high. No bubble is inserted when switching channels.
- Round-robin fairness: with all N channels continuously valid, each channel is granted exactly once in every N consecutive accepts.
- Output stability: while `out_valid && !out_ready`, `out_data` and `out_sel` are stable.
- Simultaneous drain and load in the same cycle is legal and is the normal full-rate case.

## Test plan
- Reset: drive `rst_n=0` with arbitrary inputs -> `out_valid=0`, `out_data=0`, `out_sel=0`, `in_ready=0`. After release with only `in_valid[2]`, data 0xA -> next cycle `out_data=0xA`, `out_sel=2`.
- Round-robin: N=4, all valid, `out_ready=1`, data = channel index + 5 -> `out_sel` sequence 0,1,2,3,0,1 with matching data; `in_ready` is one-hot every cycle.
- Backpressure: one word held, `out_ready=0` for 3 cycles with all channels valid -> `in_ready=0`, `out_data`/`out_sel` unchanged. On `out_ready=1` the next grant follows the old `ptr`.
- Sparse and wrap, N=3: `in_valid=3'b101` continuously -> grants 0,2,0,2. Drop all valid for 1 cycle -> `out_valid` falls, then grant resumes from `ptr`.
- Fixed priority, `MODE=1`: `in_valid=4'b1011` constant -> `out_sel` is always 0 and channels 1 and 3 never get `in_ready`. Drop `in_valid[0]` -> `out_sel=1`.
- Reset mid-stream: assert `rst_n=0` while `out_valid=1` -> `out_valid` drops immediately (asynchronous). After release, the first grant is channel 0 if it is valid.
